vdg_display_fetch: RTL
======================

// Module: vdg_display_fetch
// PURPOSE
//  Memory-side responder to the VDG display-address bus: watches DA, fetches the addressed byte
//  from shared synchronous video RAM and presents it on Q together with derived Inv/AnS.
//  Arbitrates that RAM between VDG fetches (priority) and a CPU req/ack port.
//  Sits between MC6847X (DA in, Q/Inv/AnS out) and the board SRAM.
// PARAMETERS
//  ADDR_W     16       RAM address width; all address arithmetic is modulo 2^ADDR_W
//  MEM_LAT    1        SRAM read latency in clk cycles (1..3)
//  BASE_RST   16'h0400 display base address loaded at reset
// PORTS
//  clk        in   1       pixel-domain clock (same as VDG NTSCClk)
//  reset_n    in   1       asynchronous, active-low reset
//  da         in   13      VDG display address
//  fsn        in   1       VDG field sync, active low
//  ang        in   1       alpha(0)/graphics(1) mode
//  base       in   ADDR_W  requested display base; sampled on fsn falling edge only
//  cpu_req    in   1       CPU access request, held until cpu_ack
//  cpu_we     in   1       1=write, 0=read; stable while cpu_req
//  cpu_addr   in   ADDR_W  CPU address; stable while cpu_req
//  cpu_wdata  in   8       CPU write data
//  cpu_ack    out  1       one-cycle completion pulse
//  cpu_rdata  out  8       read data, valid in cpu_ack cycle, held after
//  mem_addr   out  ADDR_W  SRAM address
//  mem_we     out  1       SRAM write strobe (one cycle)
//  mem_wdata  out  8       SRAM write data
//  mem_rdata  in   8       SRAM read data, MEM_LAT cycles after mem_addr
//  q          out  8       display byte to VDG
//  inv        out  1       q[6] & ~ang (registered with q)
//  ans        out  1       q[7] & ~ang (registered with q)
//  overrun    out  1       sticky: DA changed before previous fetch was issued
// BEHAVIOUR
//  Reset: q=0, inv=0, ans=0, cpu_ack=0, cpu_rdata=0, mem_we=0, mem_addr=0, overrun=0,
//   base_r=BASE_RST, da_r=0, FSM=IDLE, vid_pend=0. Reset mid-access aborts it; no ack issued.
//  DA change detect: da registered every cycle; da != da_r sets vid_pend and vid_addr=base_r+da
//   (zero-extended, wraps mod 2^ADDR_W). DA change while vid_pend=1 and not yet issued:
//   vid_addr replaced by newest value, overrun set.
//  Base: base_r <= base on fsn 1->0; fetch computed in that same cycle uses old base_r.
//   overrun cleared on fsn 1->0 (set wins if both in same cycle).
//  FSM: IDLE, VRD, VWAIT, CRD, CWAIT, CWR.
//   IDLE: vid_pend -> VRD; else cpu_req&~cpu_we -> CRD; else cpu_req&cpu_we -> CWR.
//   VRD: drive mem_addr=vid_addr, clear vid_pend -> VWAIT.
//   VWAIT: count MEM_LAT cycles; on last, q<=mem_rdata, inv/ans updated -> IDLE.
//   CRD: drive cpu_addr -> CWAIT; after MEM_LAT cycles capture cpu_rdata, pulse cpu_ack -> IDLE.
//   CWR: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=1 one cycle, pulse cpu_ack -> IDLE.
//  Latency (idle bus): q updates 2+MEM_LAT clk after DA changes. No preemption: worst case
//   adds one CPU access (1+MEM_LAT). CPU waits at most one video fetch plus own access.
//  Simultaneous vid_pend and cpu_req in IDLE: video wins; CPU serviced next IDLE.
//  cpu_ack then cpu_req still high next cycle = new request (CPU must drop req after ack).
//  CPU write to the address being fetched in same window: fetch returns pre- or post-write
//   data strictly per SRAM order of access (video first when both pending).
//  q/inv/ans held between fetches; ang change updates inv/ans only on next fetch.
// TESTING
//  1 reset_n low mid CWAIT -> cpu_ack never pulses, q=0, mem_we=0, FSM IDLE after release.
//  2 base=0x0400, da 0->0x005, MEM_LAT=1, mem holds 0xC5 -> mem_addr=0x0405, q=0xC5 3 clk
//    after change; ang=0 -> inv=1, ans=1; ang=1 -> inv=0, ans=0.
//  3 base=0xFFF0, da=0x0020 -> mem_addr=0x0010 (wrap).
//  4 cpu_req write 0x5A @0x0410 same cycle as da change -> video read issued first,
//    mem_we next-but-MEM_LAT cycle, cpu_ack once; readback returns 0x5A.
//  5 da changes twice in consecutive cycles while CWAIT busy -> one fetch of newest
//    address, overrun=1; cleared at next fsn falling edge.
//  6 base changed mid-field -> no effect until fsn falls; next fetch uses new base.

Source files
------------

// File: rtl/vdg_display_fetch.sv
// Video RAM responder for the VDG display-address bus: fetches the byte addressed by DA
// into Q/Inv/AnS and shares the synchronous RAM with a CPU req/ack port (video has priority).
module vdg_display_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0] BASE_RST = 16'h0400
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [12:0]       da,
    input  logic              fsn,
    input  logic              ang,
    input  logic [ADDR_W-1:0] base,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        q,
    output logic              inv,
    output logic              ans,
    output logic              overrun
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] VRD   = 3'd1;
    localparam logic [2:0] VWAIT = 3'd2;
    localparam logic [2:0] CRD   = 3'd3;
    localparam logic [2:0] CWAIT = 3'd4;
    localparam logic [2:0] CWR   = 3'd5;

    logic [2:0]        state;
    logic [12:0]       da_r;
    logic              fsn_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_pend;
    logic [1:0]        lat_cnt;
    logic              da_chg;
    logic              fsn_fall;
    logic              vid_issue;
    logic              lat_done;

    assign da_chg    = (da != da_r);
    assign fsn_fall  = fsn_r & ~fsn;
    // The fetch counts as issued on the IDLE->VRD edge, where mem_addr is loaded.
    assign vid_issue = (state == IDLE) && vid_pend;
    assign lat_done  = (lat_cnt == 2'(MEM_LAT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            da_r     <= '0;
            fsn_r    <= 1'b1;
            base_r   <= BASE_RST;
            vid_pend <= 1'b0;
            vid_addr <= '0;
            overrun  <= 1'b0;
        end else begin
            da_r  <= da;
            fsn_r <= fsn;
            if (fsn_fall)
                base_r <= base;
            // A new DA always wins over the clear, so a change landing on the issue edge is not lost.
            if (da_chg) begin
                vid_pend <= 1'b1;
                vid_addr <= base_r + ADDR_W'(da);
            end else if (vid_issue) begin
                vid_pend <= 1'b0;
            end
            if (da_chg && vid_pend && !vid_issue)
                overrun <= 1'b1;
            else if (fsn_fall)
                overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            q         <= '0;
            inv       <= 1'b0;
            ans       <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // A DA change about to raise vid_pend also holds off the CPU.
                    if (vid_pend) begin
                        mem_addr <= vid_addr;
                        state    <= VRD;
                    end else if (cpu_req && !da_chg) begin
                        mem_addr <= cpu_addr;
                        if (cpu_we) begin
                            mem_wdata <= cpu_wdata;
                            mem_we    <= 1'b1;
                            cpu_ack   <= 1'b1;
                            state     <= CWR;
                        end else begin
                            state <= CRD;
                        end
                    end
                end
                VRD: begin
                    lat_cnt <= '0;
                    state   <= VWAIT;
                end
                VWAIT: begin
                    if (lat_done) begin
                        q     <= mem_rdata;
                        inv   <= mem_rdata[6] & ~ang;
                        ans   <= mem_rdata[7] & ~ang;
                        state <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                CRD: begin
                    lat_cnt <= '0;
                    state   <= CWAIT;
                end
                CWAIT: begin
                    if (lat_done) begin
                        cpu_rdata <= mem_rdata;
                        cpu_ack   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                CWR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
